// File: rtl/kws_audio_pkg.sv
// Shared types and defaults for the KWS I2S audio front-end.
// Default timing gives 16 kHz frames from an 8.192 MHz clock.
package kws_audio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CLK_DIV_DEF     = 4;
  localparam int SLOT_BITS_DEF   = 32;
  localparam int SAMPLE_BITS_DEF = 16;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock divider: registered SCK plus single-cycle rise/fall strobes, held low when not running.
// Strobes are asserted in the cycle whose closing edge changes SCK; no backpressure.
module i2s_clk_gen
  import kws_audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = run && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_evt = wrap && !sck;
  assign fall_evt = wrap && sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kws_i2s_audio_source.sv
// I2S master for a single mic channel; emits one PCM word per frame as a one-cycle audio_valid.
// audio_valid follows the LSB-sampling SCK rise by one clk; the sink has no ready, nothing stalls.
module kws_i2s_audio_source
  import kws_audio_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int CHANNEL_SEL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   i2s_sck,
  output logic                   i2s_ws,
  input  logic                   i2s_sd,
  output logic [SAMPLE_BITS-1:0] audio_out,
  output logic                   audio_valid,
  output logic [15:0]            sample_count
);

  localparam int   BW    = $clog2(SLOT_BITS);
  localparam logic CH_WS = (CHANNEL_SEL != 0) ? WS_RIGHT : WS_LEFT;

  state_t                 state;
  logic [BW-1:0]          bit_cnt;
  logic [SAMPLE_BITS-2:0] shift_q;
  logic                   warm;

  logic                   run;
  logic                   rise_evt;
  logic                   fall_evt;
  logic                   sel_slot;
  logic                   capture;
  logic                   last_bit;
  logic                   slot_wrap;
  logic [SAMPLE_BITS-1:0] word_next;

  // Gate the divider with enable directly so SCK drops on the same edge the FSM leaves RUN.
  assign run = (state == RUN) && enable;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .sck      (i2s_sck),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  // bit_cnt 0 is the I2S one-bit delay slot; data bits occupy 1..SAMPLE_BITS.
  assign sel_slot  = (i2s_ws == CH_WS);
  assign capture   = rise_evt && sel_slot && (bit_cnt != '0) && (bit_cnt <= BW'(SAMPLE_BITS));
  assign last_bit  = capture && (bit_cnt == BW'(SAMPLE_BITS));
  assign slot_wrap = (bit_cnt == BW'(SLOT_BITS - 1));
  assign word_next = {shift_q, i2s_sd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      i2s_ws       <= WS_LEFT;
      shift_q      <= '0;
      warm         <= 1'b1;
      audio_out    <= '0;
      audio_valid  <= 1'b0;
      sample_count <= '0;
    end else begin
      audio_valid <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          i2s_ws  <= WS_LEFT;
          shift_q <= '0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
            i2s_ws  <= WS_LEFT;
            shift_q <= '0;
            warm    <= 1'b1;
          end else begin
            if (capture) shift_q <= word_next[SAMPLE_BITS-2:0];
            // The first selected slot after start-up is captured but dropped while the mic locks to WS.
            if (last_bit && !warm) begin
              audio_out    <= word_next;
              audio_valid  <= 1'b1;
              sample_count <= sample_count + 16'd1;
            end
            if (fall_evt) begin
              if (slot_wrap) begin
                bit_cnt <= '0;
                i2s_ws  <= ~i2s_ws;
                if (sel_slot) warm <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
